pipeline_input_buffer: RTL
==========================

PIPELINE_INPUT_BUFFER -- requirements
Module: pipeline_input_buffer

Interface
REQ-001 Parameter DATA_W, 32, width of each channel's data word.
REQ-002 Parameter DEPTH, 4, entries per channel FIFO; power of two, 2..16.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; 0 = in reset.
REQ-005 wr_data_1 / wr_data_2  input  DATA_W  producer data for channel 1 / 2.
REQ-006 wr_valid_1 / wr_valid_2  input  1  producer offers a word on channel 1 / 2.
REQ-007 wr_ready_1 / wr_ready_2  output  1  channel 1 / 2 accepts the word this cycle.
REQ-008 flush_1 / flush_2  input  1  discard all contents of channel 1 / 2.
REQ-009 stall_1 / stall_2  input  1  downstream pipeline 1 / 2 cannot take a word.
REQ-010 pipeline1_inputs / pipeline2_inputs  output  DATA_W  head-of-FIFO data to pipeline 1 / 2.
REQ-011 in_valid  output  2  bit0 = pipeline1_inputs valid, bit1 = pipeline2_inputs valid.
REQ-012 count_1 / count_2  output  $clog2(DEPTH)+1  current occupancy of channel 1 / 2.

Function
REQ-013 Each channel SHALL be an independent DEPTH-entry FIFO; channels share no state.
REQ-014 wr_ready_n SHALL be 1 iff count_n < DEPTH, reset is deasserted, and flush_n = 0.
REQ-015 Push: when wr_valid_n && wr_ready_n at a rising edge, the word is written at the write pointer and count_n increments.
REQ-016 in_valid[n-1] SHALL be 1 iff count_n != 0; pipeline_n_inputs SHALL present the entry at the read pointer, driven from storage with no extra register stage.
REQ-017 Pop: when in_valid[n-1] && !stall_n && !flush_n at a rising edge, the read pointer advances and count_n decrements.
REQ-018 Latency: a word pushed at edge k SHALL be visible on the outputs after edge k (one cycle) when the FIFO was empty.
REQ-019 Simultaneous push and pop in one cycle SHALL leave count_n unchanged and advance both pointers.
REQ-020 When full, a pop in the same cycle SHALL NOT enable a push; wr_ready_n is computed from the registered count only.
REQ-021 Pointers SHALL wrap modulo DEPTH; the FIFO preserves order across wrap-around.
REQ-022 While stall_n = 1, pipeline_n_inputs and in_valid[n-1] SHALL hold steady unless a flush occurs.
REQ-023 flush_n = 1 at an edge SHALL zero both pointers and count_n, and SHALL discard any push or pop presented in that cycle.
REQ-024 flush_n SHALL NOT affect the other channel.
REQ-025 count_n SHALL never exceed DEPTH or go below 0 under any input sequence.

Reset
REQ-026 While reset = 0, pointers and count_n SHALL be 0, in_valid = 2'b00, and wr_ready_1 = wr_ready_2 = 0.
REQ-027 Storage contents SHALL NOT be reset; outputs pipeline_n_inputs are don't-care while in_valid is 0.
REQ-028 Reset asserted mid-operation SHALL immediately empty both channels; on deassertion wr_ready_n = 1 from the first cycle.

Structure
REQ-029 Package pipeline_pkg SHALL hold DATA_W and DEPTH defaults and the derived pointer width.
REQ-030 One sub-module, input_fifo (single-channel FIFO with push, pop, flush, count), SHALL be instantiated twice.
REQ-031 The top level SHALL contain only the two instances plus pop, ready and in_valid wiring.

Verification
REQ-032 Reset, then push 0xA1, 0xA2 on channel 1 with stall_1 = 0 -> in_valid[0] rises one cycle later; pipeline1_inputs shows 0xA1 then 0xA2; count_1 returns to 0.
REQ-033 stall_1 = 1; push 4 words 0x10..0x13 -> count_1 = 4, wr_ready_1 = 0, and a 5th word is not accepted; release stall -> 0x10..0x13 emerge in order.
REQ-034 Run 10 words through channel 2 with DEPTH = 4 and alternating stall_2 -> wrap-around is exercised with order intact and no loss or duplication.
REQ-035 Channel 1 holds 3 words; assert flush_1 while wr_valid_1 = 1 -> count_1 = 0, in_valid[0] = 0, the pushed word is dropped, and channel 2 is unaffected.
REQ-036 Both channels partly full; drive reset low asynchronously mid-cycle -> in_valid = 00, counts = 0, and wr_ready = 0 without waiting for a clock edge.
REQ-037 Count = 2, pop and push in the same cycle -> count stays 2 and the head advances to the next word.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared defaults and derived widths for the dual-channel pipeline input buffer.
package pipeline_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int DEPTH_DEF  = 4;

   // Pointer width for a FIFO of the given depth (at least one bit).
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   localparam int PTR_W_DEF = ptr_w(DEPTH_DEF);

endpackage

// File: rtl/input_fifo.sv
// Single-channel FIFO: push, pop, flush and occupancy count.
// The read port is combinational from storage, so the head word is visible
// one cycle after it is written into an empty FIFO.
module input_fifo
   import pipeline_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic                     i_flush,
   input  logic [DATA_W-1:0]        i_wr_data,
   output logic [DATA_W-1:0]        o_rd_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full
);

   localparam int PTR_W = ptr_w(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_push;
   logic              w_pop;

   // Guard locally as well, so count can never leave 0..DEPTH.
   assign w_push    = i_push & ~o_full & ~i_flush;
   assign w_pop     = i_pop & (r_count != '0) & ~i_flush;
   assign o_full    = (r_count == FULL_CNT);
   assign o_count   = r_count;
   assign o_rd_data = r_mem[r_rd_ptr];

   // Storage is not reset; contents are meaningless while empty.
   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= i_wr_data;
   end

   // Pointers wrap naturally since DEPTH is a power of two; flush wins over push/pop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/pipeline_input_buffer.sv
// Two independent input FIFOs feeding two downstream pipelines.
// Ready is derived from the registered count only, so a pop never frees a
// slot for a push in the same cycle.
module pipeline_input_buffer
   import pipeline_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DATA_W-1:0]      wr_data_1,
   input  logic [DATA_W-1:0]      wr_data_2,
   input  logic                   wr_valid_1,
   input  logic                   wr_valid_2,
   output logic                   wr_ready_1,
   output logic                   wr_ready_2,
   input  logic                   flush_1,
   input  logic                   flush_2,
   input  logic                   stall_1,
   input  logic                   stall_2,
   output logic [DATA_W-1:0]      pipeline1_inputs,
   output logic [DATA_W-1:0]      pipeline2_inputs,
   output logic [1:0]             in_valid,
   output logic [$clog2(DEPTH):0] count_1,
   output logic [$clog2(DEPTH):0] count_2
);

   logic w_full_1, w_full_2;
   logic w_push_1, w_push_2;
   logic w_pop_1,  w_pop_2;

   assign wr_ready_1 = reset & ~w_full_1 & ~flush_1;
   assign wr_ready_2 = reset & ~w_full_2 & ~flush_2;
   assign w_push_1   = wr_valid_1 & wr_ready_1;
   assign w_push_2   = wr_valid_2 & wr_ready_2;
   assign in_valid   = {(count_2 != '0), (count_1 != '0)};
   assign w_pop_1    = in_valid[0] & ~stall_1 & ~flush_1;
   assign w_pop_2    = in_valid[1] & ~stall_2 & ~flush_2;

   input_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_1 (
      .clk       (clk),
      .rst_n     (reset),
      .i_push    (w_push_1),
      .i_pop     (w_pop_1),
      .i_flush   (flush_1),
      .i_wr_data (wr_data_1),
      .o_rd_data (pipeline1_inputs),
      .o_count   (count_1),
      .o_full    (w_full_1)
   );

   input_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo_2 (
      .clk       (clk),
      .rst_n     (reset),
      .i_push    (w_push_2),
      .i_pop     (w_pop_2),
      .i_flush   (flush_2),
      .i_wr_data (wr_data_2),
      .o_rd_data (pipeline2_inputs),
      .o_count   (count_2),
      .o_full    (w_full_2)
   );

endmodule
